step_activity_tracker: RTL

Consumes the 100 Hz divided clock from the clock divider (10 ms period) and the raw pedometer pulse. It debounces steps on 10 ms ticks and keeps a saturating total step count. It also produces a steps-per-second figure every 100 ticks and counts "active" seconds, where at least a threshold number of steps occurred. Outputs feed the display/BCD stage of the fitness tracker.

---
 rtl/step_activity_tracker_if.sv | 27 ++
 rtl/step_activity_tracker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/step_activity_tracker_if.sv
// Signal bundle between the fitness-tracker front end and the step activity tracker.
// master drives the raw tick clock and pulse; slave returns counts, strobe and debug state.
interface step_activity_tracker_if;
   logic        tick_clk_in;
   logic        pulse_in;
   logic [13:0] total_steps;
   logic [7:0]  steps_last_sec;
   logic [11:0] active_secs;
   logic        sec_strobe;
   logic        over_goal;
   logic [1:0]  dbg_state;
   logic [7:0]  dbg_win_cnt;

   // No valid/ready handshake here: inputs are free-running asynchronous levels,
   // outputs are registered levels except sec_strobe, a single-clk pulse per window.
   modport master (
      output tick_clk_in, pulse_in,
      input  total_steps, steps_last_sec, active_secs, sec_strobe, over_goal,
      input  dbg_state, dbg_win_cnt
   );

   modport slave (
      input  tick_clk_in, pulse_in,
      output total_steps, steps_last_sec, active_secs, sec_strobe, over_goal,
      output dbg_state, dbg_win_cnt
   );
endinterface

// File: rtl/step_activity_tracker.sv
// Debounces pedometer pulses on 10 ms ticks, keeps a saturating step total,
// per-second step figure and a count of active seconds.
module step_activity_tracker #(
   parameter int TICKS_PER_SEC = 100,
   parameter int DEB_TICKS     = 3,
   parameter int MAX_STEPS     = 9999,
   parameter int GOAL_STEPS    = 500,
   parameter int ACTIVE_THRESH = 2
) (
   input logic                   clk,
   input logic                   reset,
   step_activity_tracker_if.slave sif
);

   localparam int QW = $clog2(DEB_TICKS + 1);
   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [QW-1:0] DEB_C      = QW'(DEB_TICKS);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
   localparam logic [13:0]   MAX_C      = 14'(MAX_STEPS);
   localparam logic [13:0]   GOAL_C     = 14'(GOAL_STEPS);
   localparam logic [7:0]    ACT_C      = 8'(ACTIVE_THRESH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HELD = 2'd2
   } deb_state_t;

   // synchronizers and tick edge detect
   logic tick_s1, tick_s2, tick_s2_d, tick;
   logic pulse_s1, pulse_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_s1   <= 1'b0;
         tick_s2   <= 1'b0;
         tick_s2_d <= 1'b0;
         tick      <= 1'b0;
         pulse_s1  <= 1'b0;
         pulse_s   <= 1'b0;
      end else begin
         tick_s1   <= sif.tick_clk_in;
         tick_s2   <= tick_s1;
         tick_s2_d <= tick_s2;
         tick      <= tick_s2 & ~tick_s2_d;
         pulse_s1  <= sif.pulse_in;
         pulse_s   <= pulse_s1;
      end
   end

   // debounce FSM
   deb_state_t    state, state_nxt;
   logic [QW-1:0] qual, qual_nxt, qual_inc;
   logic          accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         qual  <= '0;
      end else begin
         state <= state_nxt;
         qual  <= qual_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      qual_nxt  = qual;
      accept    = 1'b0;
      qual_inc  = qual + QW'(1);
      if (tick) begin
         case (state)
            IDLE: begin
               if (pulse_s) begin
                  if (DEB_TICKS == 1) begin
                     accept    = 1'b1;
                     state_nxt = HELD;
                  end else begin
                     qual_nxt  = QW'(1);
                     state_nxt = QUAL;
                  end
               end
            end
            QUAL: begin
               if (!pulse_s) begin
                  qual_nxt  = '0;
                  state_nxt = IDLE;
               end else if (qual_inc == DEB_C) begin
                  accept    = 1'b1;
                  qual_nxt  = '0;
                  state_nxt = HELD;
               end else begin
                  qual_nxt  = qual_inc;
               end
            end
            HELD: begin
               if (!pulse_s) state_nxt = IDLE;
            end
            default: begin
               qual_nxt  = '0;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // counters and window bookkeeping
   logic [13:0]   total_steps, total_nxt;
   logic [7:0]    win_cnt, win_inc, steps_last_sec;
   logic [11:0]   active_secs;
   logic [TW-1:0] tick_idx;
   logic          sec_strobe, over_goal, win_close;

   always_comb begin
      total_nxt = total_steps;
      win_inc   = win_cnt;
      if (accept && (total_steps < MAX_C)) total_nxt = total_steps + 14'd1;
      if (accept && (win_cnt != 8'hFF))    win_inc   = win_cnt + 8'd1;
      win_close = tick && (tick_idx == TICK_LAST);
   end

   // a step accepted on the closing tick is folded into win_inc, so it lands in the closing window
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_steps    <= '0;
         win_cnt        <= '0;
         steps_last_sec <= '0;
         active_secs    <= '0;
         tick_idx       <= '0;
         sec_strobe     <= 1'b0;
         over_goal      <= 1'b0;
      end else begin
         sec_strobe  <= win_close;
         over_goal   <= (total_nxt >= GOAL_C);
         total_steps <= total_nxt;
         if (tick) begin
            if (win_close) begin
               tick_idx       <= '0;
               win_cnt        <= '0;
               steps_last_sec <= win_inc;
               if ((win_inc >= ACT_C) && (active_secs != 12'hFFF))
                  active_secs <= active_secs + 12'd1;
            end else begin
               tick_idx <= tick_idx + TW'(1);
               win_cnt  <= win_inc;
            end
         end
      end
   end

   assign sif.total_steps    = total_steps;
   assign sif.steps_last_sec = steps_last_sec;
   assign sif.active_secs    = active_secs;
   assign sif.sec_strobe     = sec_strobe;
   assign sif.over_goal      = over_goal;
   assign sif.dbg_state      = state;
   assign sif.dbg_win_cnt    = win_cnt;

endmodule
